// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the sequential double-dabble converter.
// State encodings and display limits used by the top and the bench.
package bin2bcd_seq_pkg;

  localparam int BIN2BCD_BIN_W   = 14;
  localparam int BIN2BCD_MAX_VAL = 9999;
  localparam int BIN2BCD_NDIG    = 4;
  localparam int BIN2BCD_SDIG    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a producer and bin2bcd_seq.
// The slave side is the converter, the master side drives start/bin.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       bcd0;
  logic [3:0]       bcd1;
  logic [3:0]       bcd2;
  logic [3:0]       bcd3;

  modport master (
    output start, bin,
    input  busy, done, ovf,
    input  bcd0, bcd1, bcd2, bcd3
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf,
    output bcd0, bcd1, bcd2, bcd3
  );

endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: nibbles of 5..9 get +3 before a shift.
// Inputs never exceed 9, so the 4-bit result cannot wrap.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, 16 cycles per result.
// Define BIN2BCD_SAT_EN to show 9999 instead of bin mod 10000 on overflow.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W = BIN2BCD_BIN_W
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  io
);

  localparam int SW = 4 * BIN2BCD_SDIG;
  localparam int OW = 4 * BIN2BCD_NDIG;
  localparam logic [3:0] LAST = 4'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAXV = BIN_W'(BIN2BCD_MAX_VAL);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0] sh_q, sh_d;
  logic [SW-1:0]    scr_q, scr_d;
  logic [SW-1:0]    scr_adj;
  logic             ovp_q, ovp_d;
  logic [OW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  for (genvar g = 0; g < BIN2BCD_SDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (scr_q[4*g +: 4]),
      .d_o (scr_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    ovp_d   = ovp_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          sh_d    = io.bin;
          scr_d   = '0;
          cnt_d   = '0;
          ovp_d   = (io.bin > MAXV);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, sh_d} = {scr_adj, sh_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        ovf_d  = ovp_q;
        bcd_d  = scr_q[OW-1:0];
`ifdef BIN2BCD_SAT_EN
        if (ovp_q) bcd_d = {BIN2BCD_NDIG{4'd9}};
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      ovp_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      ovp_q   <= ovp_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign io.busy = (state_q != IDLE);
  assign io.done = done_q;
  assign io.ovf  = ovf_q;
  assign io.bcd0 = bcd_q[3:0];
  assign io.bcd1 = bcd_q[7:4];
  assign io.bcd2 = bcd_q[11:8];
  assign io.bcd3 = bcd_q[15:12];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle model of accept/result timing
// with decimal arithmetic for the digits, plus directed literal checks.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  bin2bcd_seq_if bus ();

  bin2bcd_seq dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] exp_bcd(int v);
    int w;
`ifdef BIN2BCD_SAT_EN
    w = (v > 9999) ? 9999 : v;
`else
    w = v % 10000;
`endif
    return {4'(w / 1000), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a request is taken when no conversion is pending; its result
  // lands 15 edges later, and the converter is free again on the next edge.
  bit          m_active = 1'b0;
  int          m_age = 0;
  int          m_val = 0;
  logic [15:0] m_bcd = '0;
  bit          m_ovf = 1'b0;
  bit          m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_age = 0;
      m_bcd = '0;
      m_ovf = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_age++;
        if (m_age == 15) begin
          m_active = 1'b0;
          m_done = 1'b1;
          m_bcd = exp_bcd(m_val);
          m_ovf = (m_val > 9999);
        end
      end else if (bus.start === 1'b1) begin
        m_active = 1'b1;
        m_age = 0;
        m_val = int'(bus.bin);
      end
    end
  end

  logic [15:0] dig;
  assign dig = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};

  always @(negedge clk) begin
    chk("busy", int'(bus.busy), int'(m_active));
    chk("done", int'(bus.done), int'(m_done));
    chk("ovf", int'(bus.ovf), int'(m_ovf));
    chk("bcd", int'(dig), int'(m_bcd));
  end

  task automatic wait_done(string name, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        c = cyc;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: no done within 40 cycles", name);
  endtask

  task automatic pulse(int v);
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.bin = 14'(v);
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    bus.bin = 14'($urandom_range(0, 16383));
  endtask

  int c1, c2;
  int bvals[11] = '{0, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16383};

  initial begin
    bus.start = 1'b0;
    bus.bin = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    chk("rst_bcd", int'(dig), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ovf", int'(bus.ovf), 0);

    chk("model_1234", int'(exp_bcd(1234)), 'h1234);
    chk("model_9999", int'(exp_bcd(9999)), 'h9999);

    @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.bin = 14'd1234;
    @(posedge clk);
    #1;
    chk("t2_busy_rise", int'(bus.busy), 1);
    #1;
    bus.start = 1'b0;
    bus.bin = 14'd3;
    wait_done("t2", c1);
    chk("t2_bcd", int'(dig), 'h1234);
    chk("t2_ovf", int'(bus.ovf), 0);

    @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.bin = 14'd0;
    @(posedge clk);
    #2;
    bus.bin = 14'd9999;
    wait_done("t3a", c1);
    chk("t3_zero", int'(dig), 'h0000);
    wait_done("t3b", c2);
    bus.start = 1'b0;
    chk("t3_nines", int'(dig), 'h9999);
    chk("t3_spacing", c2 - c1, 16);

    pulse(12345);
    wait_done("t4", c1);
    chk("t4_ovf", int'(bus.ovf), 1);
`ifdef BIN2BCD_SAT_EN
    chk("t4_bcd", int'(dig), 'h9999);
`else
    chk("t4_bcd", int'(dig), 'h2345);
`endif

    pulse(42);
    repeat (3) @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.bin = 14'd77;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    wait_done("t5", c1);
    chk("t5_bcd", int'(dig), 'h0042);

    pulse(5678);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_bcd", int'(dig), 0);
    chk("t6_async_busy", int'(bus.busy), 0);
    chk("t6_async_ovf", int'(bus.ovf), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("t6_no_done", int'(bus.done), 0);
    end
    pulse(5678);
    wait_done("t6", c1);
    chk("t6_bcd", int'(dig), 'h5678);

    foreach (bvals[i]) begin
      pulse(bvals[i]);
      wait_done("bound", c1);
    end

    for (int i = 0; i < 30000; i++) begin
      @(posedge clk);
      #2;
      bus.start = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        bus.bin = 14'($urandom_range(9990, 10010));
      else
        bus.bin = 14'($urandom_range(0, 16383));
    end
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
